// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment scan display: blank pattern, digit limit and hex font.
package seg_display_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam int         MAX_DIGITS = 8;

    // Active-low glyphs, bit7 (dp) held off; index is the hex value.
    localparam logic [7:0] FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [6:0] hexToSeg(input logic [3:0] nibble);
        return FONT[nibble][6:0];
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble + decimal-point to active-low segment pattern.
module seg_hex_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = {~dp_i, hexToSeg(nibble_i)};

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment driver with guard gaps, frame latching and leading-zero suppression.
// Optional digit blinking is enabled by defining SEG_SCAN_DISPLAY_BLINK_EN.
module seg_scan_display
    import seg_display_pkg::*;
#(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [15:0] REFRESH_DIV  = 16'd50000,
`ifdef SEG_SCAN_DISPLAY_BLINK_EN
    parameter int          BLINK_FRAMES = 32,
`endif
    parameter logic [15:0] GUARD_CYCLES = 16'd500
)
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_mask_i,
`ifdef SEG_SCAN_DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
`endif
    input  logic                    lz_en_i,
    output logic [7:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_start_o
);

    localparam int                IDX_W    = $clog2(MAX_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [15:0]             pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    frameValid_q, frameValid_d;
    logic [4*NUM_DIGITS-1:0] digitsLat_q, digitsLat_d;
    logic [NUM_DIGITS-1:0]   dpLat_q, dpLat_d;
    logic [NUM_DIGITS-1:0]   blankLat_q, blankLat_d;
    logic                    lzLat_q, lzLat_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frameStart_q;

    logic                    tick, capture;
    logic [NUM_DIGITS-1:0]   suppress, blinkHide;
    logic [3:0]              selNibble;
    logic                    selDp, selBlank, selSuppress;
    logic [7:0]              decSeg;

    assign tick    = (pre_q == REFRESH_DIV - 16'd1);
    assign capture = tick && (idx_q == '0);

    // Next-state values; outputs are derived from these so seg/an never lag pre/idx.
    always_comb begin
        pre_d        = tick ? 16'd0 : pre_q + 16'd1;
        idx_d        = idx_q;
        if (tick) begin
            idx_d = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
        end
        frameValid_d = frameValid_q | capture;
        digitsLat_d  = capture ? digits_i     : digitsLat_q;
        dpLat_d      = capture ? dp_i         : dpLat_q;
        blankLat_d   = capture ? blank_mask_i : blankLat_q;
        lzLat_d      = capture ? lz_en_i      : lzLat_q;
    end

`ifdef SEG_SCAN_DISPLAY_BLINK_EN
    logic [NUM_DIGITS-1:0] blinkLat_q, blinkLat_d;
    logic                  blinkPhase_q, blinkPhaseLat_q, blinkPhaseLat_d;
    logic [15:0]           blinkCnt_q;

    // The phase is latched with the frame so a blink change never tears a frame.
    assign blinkLat_d      = capture ? blink_mask_i : blinkLat_q;
    assign blinkPhaseLat_d = capture ? blinkPhase_q : blinkPhaseLat_q;
    assign blinkHide       = blinkPhaseLat_d ? blinkLat_d : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blinkLat_q      <= '0;
            blinkPhase_q    <= 1'b0;
            blinkPhaseLat_q <= 1'b0;
            blinkCnt_q      <= '0;
        end else begin
            blinkLat_q      <= blinkLat_d;
            blinkPhaseLat_q <= blinkPhaseLat_d;
            if (frameStart_q) begin
                if (blinkCnt_q == 16'(BLINK_FRAMES - 1)) begin
                    blinkCnt_q   <= '0;
                    blinkPhase_q <= ~blinkPhase_q;
                end else begin
                    blinkCnt_q <= blinkCnt_q + 16'd1;
                end
            end
        end
    end
`else
    assign blinkHide = '0;
`endif

    // A digit is suppressed when it and every digit to its left are zero; digit 0 always shows.
    always_comb begin
        logic zeroAbove;
        zeroAbove = 1'b1;
        suppress  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeroAbove   = zeroAbove & (digitsLat_d[4*i +: 4] == 4'd0);
            suppress[i] = lzLat_d & zeroAbove & (i != 0);
        end
    end

    always_comb begin
        selNibble   = '0;
        selDp       = 1'b0;
        selBlank    = 1'b0;
        selSuppress = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                selNibble   = digitsLat_d[4*i +: 4];
                selDp       = dpLat_d[i];
                selBlank    = blankLat_d[i] | blinkHide[i];
                selSuppress = suppress[i];
            end
        end
    end

    seg_hex_decoder u_decoder (
        .nibble_i (selNibble),
        .dp_i     (selDp),
        .seg_o    (decSeg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (frameValid_d && (pre_d >= GUARD_CYCLES) && !selBlank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_d != IDX_W'(i));
            end
            seg_d = selSuppress ? {~selDp, 7'h7F} : decSeg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q        <= '0;
            idx_q        <= '0;
            frameValid_q <= 1'b0;
            digitsLat_q  <= '0;
            dpLat_q      <= '0;
            blankLat_q   <= '0;
            lzLat_q      <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frameStart_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            frameValid_q <= frameValid_d;
            digitsLat_q  <= digitsLat_d;
            dpLat_q      <= dpLat_d;
            blankLat_q   <= blankLat_d;
            lzLat_q      <= lzLat_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frameStart_q <= capture;
        end
    end

    assign seg_o         = seg_q;
    assign an_o          = an_q;
    assign frame_start_o = frameStart_q;

endmodule
